// File: rtl/swc_pkg.sv
// Shared definitions for the switch-core ingress cell packer: cell width,
// descriptor layout, packer FSM states and the descriptor assembly helper.
package swc_pkg;

  localparam int CELL_W       = 128;
  localparam int DESC_VB_MSB  = 15;
  localparam int DESC_PM_MSB  = 11;
  localparam int DESC_LEN_MSB = 7;
  localparam int MAX_WORDS    = 95;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FRAME    = 2'd1,
    ST_WAIT_LKP = 2'd2,
    ST_EMIT     = 2'd3
  } swc_state_e;

  function automatic logic [15:0] make_desc(input logic [3:0] vb,
                                            input logic [3:0] pm,
                                            input logic [7:0] len);
    logic [15:0] d;
    d = 16'h0000;
    d[DESC_VB_MSB -: 4]  = vb;
    d[DESC_PM_MSB -: 4]  = pm;
    d[DESC_LEN_MSB -: 8] = len;
    return d;
  endfunction

endpackage

// File: rtl/swc_lkp_hold.sv
// Single-entry holding register for the forwarding decision. A result offered
// in the same cycle it is consumed bypasses the register.
module swc_lkp_hold
  import swc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lkp_portmap_i,
  input  logic       lkp_valid_i,
  output logic       lkp_ready_o,
  input  logic       consume_i,
  output logic       avail_o,
  output logic [3:0] portmap_o
);

  logic       held_q, held_d;
  logic [3:0] pm_q, pm_d;

  assign lkp_ready_o = ~held_q;
  assign avail_o     = held_q | lkp_valid_i;
  assign portmap_o   = held_q ? pm_q : lkp_portmap_i;

  // Capture a new result only while empty; consumption frees the entry.
  always_comb begin
    held_d = held_q;
    pm_d   = pm_q;
    if (consume_i) begin
      held_d = 1'b0;
    end else if (lkp_valid_i && !held_q) begin
      held_d = 1'b1;
      pm_d   = lkp_portmap_i;
    end else begin
      held_d = held_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= 1'b0;
      pm_q   <= 4'd0;
    end else begin
      held_q <= held_d;
      pm_q   <= pm_d;
    end
  end

endmodule

// File: rtl/swc_cell_packer.sv
// Packs one byte-serial frame into 128-bit cells and emits one pointer
// descriptor per frame once its forwarding decision is available.
module swc_cell_packer
  import swc_pkg::*;
#(
  parameter int MAX_BYTES = 1518,
  parameter int MAX_WORDS = (MAX_BYTES + 15) / 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_err,
  output logic              in_ready,
  input  logic [3:0]        lkp_portmap,
  input  logic              lkp_valid,
  output logic              lkp_ready,
  input  logic              cell_bp,
  output logic [CELL_W-1:0] cell_data_fifo_din,
  output logic              cell_data_fifo_wr,
  output logic [15:0]       cell_ptr_fifo_din,
  output logic              cell_ptr_fifo_wr,
  output logic [15:0]       stat_drop_cnt
);

  localparam logic [7:0] MAX_WORDS_W = 8'(MAX_WORDS);

  swc_state_e        state_q;
  logic              rdy_en_q, err_q, oversize_q;
  logic [3:0]        byte_idx_q;
  logic [7:0]        word_cnt_q;
  logic [CELL_W-1:0] word_q, data_din_q;
  logic              data_wr_q, ptr_wr_q;
  logic [15:0]       ptr_din_q, drop_cnt_q;

  logic              byte_acc_s, word_full_s, lkp_avail_s, lkp_consume_s, drop_s;
  logic [3:0]        lkp_pm_s;
  logic [6:0]        lane_s;
  logic [CELL_W-1:0] word_ins_s;

  swc_lkp_hold u_lkp_hold (
    .clk          (clk),
    .rst          (rst),
    .lkp_portmap_i(lkp_portmap),
    .lkp_valid_i  (lkp_valid),
    .lkp_ready_o  (lkp_ready),
    .consume_i    (lkp_consume_s),
    .avail_o      (lkp_avail_s),
    .portmap_o    (lkp_pm_s)
  );

  // Backpressure gates only the start of a frame; mid-frame the core has headroom.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = rdy_en_q & ~cell_bp;
      ST_FRAME: in_ready = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  assign byte_acc_s    = in_valid & in_ready;
  assign word_full_s   = (word_cnt_q == MAX_WORDS_W);
  assign lane_s        = {~byte_idx_q, 3'b000};
  assign lkp_consume_s = (state_q == ST_WAIT_LKP) & lkp_avail_s;
  assign drop_s        = err_q | oversize_q;

  // Current word with the incoming byte dropped into its lane, MSB first.
  always_comb begin
    word_ins_s = word_q;
    word_ins_s[lane_s +: 8] = in_data;
  end

  // Packer FSM with its counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rdy_en_q   <= 1'b0;
      err_q      <= 1'b0;
      oversize_q <= 1'b0;
      byte_idx_q <= 4'd0;
      word_cnt_q <= 8'd0;
      word_q     <= '0;
      data_din_q <= '0;
      data_wr_q  <= 1'b0;
      ptr_din_q  <= 16'h0000;
      ptr_wr_q   <= 1'b0;
      drop_cnt_q <= 16'h0000;
    end else begin
      rdy_en_q  <= 1'b1;
      data_wr_q <= 1'b0;
      ptr_wr_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FRAME: begin
          if (byte_acc_s) begin
            byte_idx_q <= byte_idx_q + 4'd1;
            if (word_full_s) begin
              oversize_q <= 1'b1;
            end else if (byte_idx_q == 4'd15 || in_last) begin
              data_din_q <= word_ins_s;
              data_wr_q  <= 1'b1;
              word_q     <= '0;
              word_cnt_q <= word_cnt_q + 8'd1;
            end else begin
              word_q <= word_ins_s;
            end
            if (in_last) begin
              err_q   <= in_err;
              state_q <= ST_WAIT_LKP;
            end else begin
              state_q <= ST_FRAME;
            end
          end
        end
        ST_WAIT_LKP: begin
          if (lkp_avail_s) begin
            ptr_din_q <= make_desc(byte_idx_q, drop_s ? 4'd0 : lkp_pm_s, word_cnt_q);
            ptr_wr_q  <= 1'b1;
            if (drop_s && drop_cnt_q != 16'hFFFF) begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          err_q      <= 1'b0;
          oversize_q <= 1'b0;
          byte_idx_q <= 4'd0;
          word_cnt_q <= 8'd0;
          word_q     <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cell_data_fifo_din = data_din_q;
  assign cell_data_fifo_wr  = data_wr_q;
  assign cell_ptr_fifo_din  = ptr_din_q;
  assign cell_ptr_fifo_wr   = ptr_wr_q;
  assign stat_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_swc_cell_packer.sv
// Directed bench for swc_cell_packer: hand-computed descriptors, word
// contents, latencies, backpressure and reset behaviour.
module tb_swc_cell_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid, in_last, in_err, in_ready;
  logic [3:0]   lkp_portmap;
  logic         lkp_valid, lkp_ready;
  logic         cell_bp;
  logic [127:0] cell_data_fifo_din;
  logic         cell_data_fifo_wr;
  logic [15:0]  cell_ptr_fifo_din;
  logic         cell_ptr_fifo_wr;
  logic [15:0]  stat_drop_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int data_cyc = 0, ptr_cyc = 0, last_cyc = 0, lkp_cyc = 0;
  int acc_cnt = 0, emit_rdy_viol = 0;
  logic [127:0] wq[$];
  logic [15:0]  pq[$];

  swc_cell_packer dut (
    .clk               (clk),
    .rst               (rst),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_last           (in_last),
    .in_err            (in_err),
    .in_ready          (in_ready),
    .lkp_portmap       (lkp_portmap),
    .lkp_valid         (lkp_valid),
    .lkp_ready         (lkp_ready),
    .cell_bp           (cell_bp),
    .cell_data_fifo_din(cell_data_fifo_din),
    .cell_data_fifo_wr (cell_data_fifo_wr),
    .cell_ptr_fifo_din (cell_ptr_fifo_din),
    .cell_ptr_fifo_wr  (cell_ptr_fifo_wr),
    .stat_drop_cnt     (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and writes mid-cycle.
  always @(negedge clk) begin
    if (cell_data_fifo_wr) begin
      wq.push_back(cell_data_fifo_din);
      data_cyc <= cyc;
    end
    if (cell_ptr_fifo_wr) begin
      pq.push_back(cell_ptr_fifo_din);
      ptr_cyc <= cyc;
      if (in_ready) emit_rdy_viol <= emit_rdy_viol + 1;
    end
    if (in_valid && in_ready) begin
      acc_cnt <= acc_cnt + 1;
      if (in_last) last_cyc <= cyc;
    end
    if (lkp_valid && lkp_ready) lkp_cyc <= cyc;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_val(input int base, input int i);
    return 8'(i * 3 + base);
  endfunction

  function automatic logic [127:0] exp_word(input int base, input int w, input int n);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (16 * w + k < n) r[127 - 8 * k -: 8] = byte_val(base, 16 * w + k);
    end
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last, input logic err);
    int t;
    t = 0;
    in_data = d; in_valid = 1'b1; in_last = last; in_err = err;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("byte_accept_timeout", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input bit err, input int bp_at);
    for (int i = 0; i < n; i++) begin
      if (i == bp_at) cell_bp = 1'b1;
      send_byte(byte_val(base, i), i == n - 1, err && (i == n - 1));
    end
    cell_bp = 1'b0;
  endtask

  task automatic give_lkp(input logic [3:0] pm);
    int t;
    t = 0;
    lkp_portmap = pm; lkp_valid = 1'b1;
    @(negedge clk);
    while (!lkp_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!lkp_ready) chk("lkp_accept_timeout", 128'(lkp_ready), 128'd1);
    @(posedge clk); #1;
    lkp_valid = 1'b0;
  endtask

  task automatic wait_ptr(input int n);
    int t;
    t = 0;
    while (pq.size() < n && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ptr_wait", 128'(pq.size() >= n), 128'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd0);
    chk({tag, "_lkp_ready"}, 128'(lkp_ready), 128'd1);
    chk({tag, "_data_wr"}, 128'(cell_data_fifo_wr), 128'd0);
    chk({tag, "_ptr_wr"}, 128'(cell_ptr_fifo_wr), 128'd0);
    chk({tag, "_data_din"}, cell_data_fifo_din, 128'd0);
    chk({tag, "_ptr_din"}, 128'(cell_ptr_fifo_din), 128'd0);
    chk({tag, "_drop"}, 128'(stat_drop_cnt), 128'd0);
  endtask

  initial begin
    int w0, p0, a0, viol;
    logic [127:0] w4e;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
    lkp_portmap = 4'h0; lkp_valid = 1'b0; cell_bp = 1'b0;

    // Reset values and the one-cycle in_ready hold-off.
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    #1 chk("rdy_first_cycle", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    chk("rdy_after_rst", 128'(in_ready), 128'd1);

    // 64-byte frame, lookup held beforehand.
    give_lkp(4'b0010);
    w0 = wq.size(); p0 = pq.size();
    send_frame(64, 16, 1'b0, -1);
    wait_ptr(p0 + 1);
    chk("f64_words", 128'(wq.size() - w0), 128'd4);
    for (int w = 0; w < 4; w++) chk("f64_word", wq[w0 + w], exp_word(16, w, 64));
    chk("f64_desc", 128'(pq[p0]), 128'h0204);
    chk("f64_ptr_lat", 128'(ptr_cyc - last_cyc), 128'd2);
    chk("f64_data_lat", 128'(data_cyc - last_cyc), 128'd1);

    // 65-byte frame: partial last word with zero padding.
    give_lkp(4'b0010);
    w0 = wq.size(); p0 = pq.size();
    send_frame(65, 65, 1'b0, -1);
    wait_ptr(p0 + 1);
    w4e = {8'h01, 120'h0};
    chk("f65_words", 128'(wq.size() - w0), 128'd5);
    chk("f65_word0", wq[w0], exp_word(65, 0, 65));
    chk("f65_word4", wq[w0 + 4], w4e);
    chk("f65_desc", 128'(pq[p0]), 128'h1205);

    // Late lookup: 20 cycles after in_last.
    p0 = pq.size();
    send_frame(16, 5, 1'b0, -1);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) viol++;
    end
    chk("late_rdy_low", 128'(viol), 128'd0);
    chk("late_no_ptr", 128'(pq.size() - p0), 128'd0);
    @(posedge clk); #1;
    give_lkp(4'b0100);
    wait_ptr(p0 + 1);
    chk("late_desc", 128'(pq[p0]), 128'h0401);
    chk("late_ptr_lat", 128'(ptr_cyc - lkp_cyc), 128'd1);
    chk("late_rdy_after_emit", 128'(in_ready), 128'd1);

    // Errored frame forces portmap to zero and counts a drop.
    give_lkp(4'b1111);
    w0 = wq.size(); p0 = pq.size();
    send_frame(64, 119, 1'b1, -1);
    wait_ptr(p0 + 1);
    chk("err_words", 128'(wq.size() - w0), 128'd4);
    chk("err_desc", 128'(pq[p0]), 128'h0004);
    chk("err_drop_cnt", 128'(stat_drop_cnt), 128'd1);

    // Oversize frame: truncated to 95 words, all bytes still accepted.
    give_lkp(4'b0011);
    w0 = wq.size(); p0 = pq.size(); a0 = acc_cnt;
    send_frame(1600, 0, 1'b0, -1);
    wait_ptr(p0 + 1);
    chk("big_words", 128'(wq.size() - w0), 128'd95);
    chk("big_accepted", 128'(acc_cnt - a0), 128'd1600);
    chk("big_last_word", wq[w0 + 94], exp_word(0, 94, 1600));
    chk("big_desc_pm", 128'(pq[p0][11:8]), 128'd0);
    chk("big_desc_len", 128'(pq[p0][7:0]), 128'h5F);
    chk("big_desc", 128'(pq[p0]), 128'h005F);
    chk("big_drop_cnt", 128'(stat_drop_cnt), 128'd2);

    // Backpressure in IDLE blocks the frame start.
    cell_bp = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    a0 = acc_cnt; viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) viol++;
    end
    @(posedge clk); #1;
    chk("bp_rdy_low", 128'(viol), 128'd0);
    chk("bp_no_accept", 128'(acc_cnt - a0), 128'd0);
    in_valid = 1'b0; cell_bp = 1'b0;

    // Backpressure raised mid-frame is ignored.
    give_lkp(4'b1000);
    w0 = wq.size(); p0 = pq.size(); a0 = acc_cnt;
    send_frame(20, 32, 1'b0, 5);
    wait_ptr(p0 + 1);
    chk("bpmid_accepted", 128'(acc_cnt - a0), 128'd20);
    chk("bpmid_word1", wq[w0 + 1], exp_word(32, 1, 20));
    chk("bpmid_desc", 128'(pq[p0]), 128'h4802);

    // Asynchronous reset mid-frame discards everything.
    give_lkp(4'b0001);
    p0 = pq.size();
    for (int i = 0; i < 10; i++) send_byte(byte_val(9, i), 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("midrst_no_ptr", 128'(pq.size() - p0), 128'd0);

    // Recovery with a 1-word, 3-byte frame.
    give_lkp(4'b0001);
    w0 = wq.size(); p0 = pq.size();
    send_frame(3, 144, 1'b0, -1);
    wait_ptr(p0 + 1);
    chk("short_words", 128'(wq.size() - w0), 128'd1);
    chk("short_word", wq[w0], exp_word(144, 0, 3));
    chk("short_desc", 128'(pq[p0]), 128'h3101);
    chk("emit_rdy_low", 128'(emit_rdy_viol), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
